// File: rtl/clmulseq_pkg.sv
// Shared BMU definitions: ClmulSelect encodings and the carry-less multiplier FSM state type.
package clmulseq_pkg;

  localparam logic [1:0] CLMUL  = 2'b01;
  localparam logic [1:0] CLMULR = 2'b10;
  localparam logic [1:0] CLMULH = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/clmulseq_clmulstep.sv
// One iteration of the carry-less product: folds BITSPERCYCLE multiplier bits into P.
// Purely combinational; no backpressure.
module clmulstep #(
  parameter int WIDTH        = 32,
  parameter int BITSPERCYCLE = 1
) (
  input  logic [2*WIDTH-1:0]      p,
  input  logic [2*WIDTH-1:0]      ashift,
  input  logic [BITSPERCYCLE-1:0] bbits,
  output logic [2*WIDTH-1:0]      pnext
);

  always_comb begin
    pnext = p;
    for (int i = 0; i < BITSPERCYCLE; i++) begin
      if (bbits[i]) pnext = pnext ^ (ashift << i);
    end
  end

endmodule

// File: rtl/clmulseq.sv
// Iterative carry-less multiplier (clmul/clmulh/clmulr); latency WIDTH/BITSPERCYCLE+1 cycles from Start.
// Start is ignored while Busy (no queuing); Flush aborts. `CLMULSEQ_CLMULR_EN enables the clmulr slice.
module clmulseq
  import clmulseq_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int BITSPERCYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Flush,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ClmulSelect,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int K  = WIDTH / BITSPERCYCLE;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  state_t             state;
  logic [2*WIDTH-1:0] ashift;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] pnext;
  logic [WIDTH-1:0]   bsh;
  logic [1:0]         sel;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   slice;

  clmulstep #(
    .WIDTH        (WIDTH),
    .BITSPERCYCLE (BITSPERCYCLE)
  ) u_step (
    .p      (p),
    .ashift (ashift),
    .bbits  (bsh[BITSPERCYCLE-1:0]),
    .pnext  (pnext)
  );

  // Slice from pnext so the final step's product is registered in the same edge.
  always_comb begin
    slice = '0;
    case (sel)
      CLMUL:  slice = pnext[WIDTH-1:0];
      CLMULH: slice = pnext[2*WIDTH-1:WIDTH];
`ifdef CLMULSEQ_CLMULR_EN
      CLMULR: slice = pnext[2*WIDTH-2:WIDTH-1];
`endif
      default: slice = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Result <= '0;
      cnt    <= '0;
      ashift <= '0;
      p      <= '0;
      bsh    <= '0;
      sel    <= '0;
    end else begin
      Done <= 1'b0;
      if (Flush) begin
        state <= IDLE;
        Busy  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (Start) begin
              ashift <= {{WIDTH{1'b0}}, A};
              bsh    <= B;
              sel    <= ClmulSelect;
              p      <= '0;
              cnt    <= '0;
              state  <= BUSY;
              Busy   <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
          BUSY: begin
            p      <= pnext;
            ashift <= ashift << BITSPERCYCLE;
            bsh    <= bsh >> BITSPERCYCLE;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(K - 1)) begin
              state  <= DONE;
              Busy   <= 1'b0;
              Done   <= 1'b1;
              Result <= slice;
            end
          end
          default: begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clmulseq.sv
// Bench for clmulseq: one instance with BITSPERCYCLE=1 (index 0) and one with 4 (index 1).
module tb_clmulseq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start [2];
  logic        flush [2];
  logic [31:0] a [2];
  logic [31:0] b [2];
  logic [1:0]  sel [2];
  logic        busy [2];
  logic        done [2];
  logic [31:0] result [2];

  int total = 0;
  int bad = 0;
  logic [31:0] last_exp [2];

  always #5 clk = ~clk;

  clmulseq #(.WIDTH(32), .BITSPERCYCLE(1)) dut1 (
    .clk(clk), .reset(reset), .Start(start[0]), .Flush(flush[0]),
    .A(a[0]), .B(b[0]), .ClmulSelect(sel[0]),
    .Busy(busy[0]), .Done(done[0]), .Result(result[0])
  );

  clmulseq #(.WIDTH(32), .BITSPERCYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .Start(start[1]), .Flush(flush[1]),
    .A(a[1]), .B(b[1]), .ClmulSelect(sel[1]),
    .Busy(busy[1]), .Done(done[1]), .Result(result[1])
  );

  // Carry-less product by definition: XOR of A shifted by every set bit position of B.
  function automatic logic [63:0] clprod(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] acc = 64'h0;
    for (int i = 0; i < 32; i++)
      if (y[i]) acc = acc ^ ({32'h0, x} << i);
    return acc;
  endfunction

  function automatic logic [31:0] ref_res(input logic [31:0] x, input logic [31:0] y,
                                          input logic [1:0] s);
    logic [63:0] pr = clprod(x, y);
    case (s)
      2'b01: return pr[31:0];
      2'b11: return pr[63:32];
`ifdef CLMULSEQ_CLMULR_EN
      2'b10: return pr[62:31];
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic int kval(input int d);
    return (d == 0) ? 32 : 8;
  endfunction

  task automatic run_op(input int d, input logic [31:0] av, input logic [31:0] bv,
                        input logic [1:0] sv, output logic [31:0] res, output int lat);
    a[d] = av; b[d] = bv; sel[d] = sv; start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    lat = 1;
    while (!done[d] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = result[d];
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      total++; if (busy[d] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got=%b exp=0", d, busy[d]); end
      total++; if (done[d] !== 1'b0) begin bad++; $display("FAIL reset_done[%0d] got=%b exp=0", d, done[d]); end
      total++; if (result[d] !== 32'h0) begin bad++; $display("FAIL reset_result[%0d] got=%h exp=0", d, result[d]); end
    end
  endtask

  task automatic test_directed;
    logic [31:0] r;
    int lat;
    logic [31:0] exp_r;
    run_op(0, 32'd3, 32'd3, 2'b01, r, lat);
    total++; if (lat != 33) begin bad++; $display("FAIL bpc1_latency got=%0d exp=33", lat); end
    total++; if (r !== 32'h5) begin bad++; $display("FAIL bpc1_clmul got=%h exp=00000005", r); end
    run_op(0, 32'h80000000, 32'h80000000, 2'b11, r, lat);
    total++; if (r !== 32'h40000000) begin bad++; $display("FAIL bpc1_clmulh got=%h exp=40000000", r); end
    run_op(0, 32'h80000000, 32'h80000000, 2'b10, r, lat);
`ifdef CLMULSEQ_CLMULR_EN
    exp_r = 32'h80000000;
`else
    exp_r = 32'h0;
`endif
    total++; if (r !== exp_r) begin bad++; $display("FAIL bpc1_clmulr got=%h exp=%h", r, exp_r); end
    total++; if (lat != 33) begin bad++; $display("FAIL bpc1_clmulr_latency got=%0d exp=33", lat); end
    run_op(1, 32'hFFFFFFFF, 32'h3, 2'b01, r, lat);
    total++; if (lat != 9) begin bad++; $display("FAIL bpc4_latency got=%0d exp=9", lat); end
    total++; if (r !== 32'h1) begin bad++; $display("FAIL bpc4_clmul got=%h exp=00000001", r); end
    run_op(1, 32'hFFFFFFFF, 32'h3, 2'b11, r, lat);
    total++; if (r !== 32'h1) begin bad++; $display("FAIL bpc4_clmulh got=%h exp=00000001", r); end
    run_op(1, 32'hFFFFFFFF, 32'h3, 2'b00, r, lat);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL bpc4_reserved got=%h exp=0", r); end
    last_exp[0] = exp_r;
    last_exp[1] = 32'h0;
  endtask

  task automatic test_random;
    logic [31:0] r, av, bv, e;
    logic [1:0] sv;
    int lat;
    for (int n = 0; n < 24; n++) begin
      int d = n % 2;
      av = $urandom; bv = $urandom; sv = 2'($urandom_range(0, 3));
      e = ref_res(av, bv, sv);
      run_op(d, av, bv, sv, r, lat);
      total++; if (r !== e || lat != kval(d) + 1)
        begin bad++; $display("FAIL random[%0d] dut=%0d sel=%0d got=%h lat=%0d exp=%h lat=%0d", n, d, sv, r, lat, e, kval(d) + 1); end
      last_exp[d] = e;
    end
  endtask

  task automatic test_flush;
    logic [31:0] r, e;
    int lat, seen;
    a[0] = $urandom; b[0] = $urandom | 32'h1; sel[0] = 2'b01; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (9) @(negedge clk);
    flush[0] = 1'b1;
    @(negedge clk);
    flush[0] = 1'b0;
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy[0]); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done[0]) seen++;
      @(negedge clk);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL flush_no_done got=%0d pulses exp=0", seen); end
    total++; if (result[0] !== last_exp[0]) begin bad++; $display("FAIL flush_result_hold got=%h exp=%h", result[0], last_exp[0]); end
    e = ref_res(32'h1234_5678, 32'h9abc_def1, 2'b11);
    run_op(0, 32'h1234_5678, 32'h9abc_def1, 2'b11, r, lat);
    total++; if (r !== e || lat != 33) begin bad++; $display("FAIL flush_restart got=%h lat=%0d exp=%h lat=33", r, lat, e); end
    last_exp[0] = e;
  endtask

  task automatic test_back_to_back;
    logic [31:0] a0, b0, a1, b1, e0, e1;
    logic [1:0] s0, s1;
    int lat;
    a0 = $urandom; b0 = $urandom; s0 = 2'b01;
    a1 = $urandom; b1 = $urandom; s1 = 2'b11;
    e0 = ref_res(a0, b0, s0); e1 = ref_res(a1, b1, s1);
    a[1] = a0; b[1] = b0; sel[1] = s0; start[1] = 1'b1;
    lat = 0;
    // Start held high with operands churning while busy
    do begin
      @(negedge clk);
      lat++;
      if (!done[1]) begin a[1] = $urandom; b[1] = $urandom; sel[1] = 2'($urandom); end
    end while (!done[1] && lat < 200);
    total++; if (result[1] !== e0 || lat != 9) begin bad++; $display("FAIL hold_start got=%h lat=%0d exp=%h lat=9", result[1], lat, e0); end
    total++; if (busy[1] !== 1'b0) begin bad++; $display("FAIL done_cycle_busy got=%b exp=0", busy[1]); end
    a[1] = a1; b[1] = b1; sel[1] = s1;
    @(negedge clk);
    start[1] = 1'b0;
    lat = 1;
    while (!done[1] && lat < 200) begin
      a[1] = $urandom; b[1] = $urandom;
      @(negedge clk);
      lat++;
    end
    total++; if (result[1] !== e1 || lat != 9) begin bad++; $display("FAIL back_to_back got=%h lat=%0d exp=%h lat=9", result[1], lat, e1); end
    last_exp[1] = e1;
  endtask

  task automatic test_reset_mid;
    int seen;
    a[0] = 32'hdead_beef; b[0] = 32'h0f0f_0f0f; sel[0] = 2'b01; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy[0]); end
    total++; if (done[0] !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b exp=0", done[0]); end
    total++; if (result[0] !== 32'h0) begin bad++; $display("FAIL midreset_result got=%h exp=0", result[0]); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done[0]) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midreset_no_done got=%0d pulses exp=0", seen); end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; flush[d] = 1'b0; a[d] = '0; b[d] = '0; sel[d] = '0;
      last_exp[d] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset;
    test_directed;
    test_random;
    test_flush;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
